mems_dac_spi_tx: RTL and testbench

//  SPI transmitter that drives the MEMS mirror DAC. It answers the MEMS scan controller's start/busy handshake.
//  On a start pulse it latches one DAC command word from the scan-pattern ROM.
//  It shifts the word out MSB-first, frames it with SYNC_n, then enforces an inter-word gap.

---
 rtl/mems_spi_pkg.sv | 33 +++
 rtl/mems_spi_tick_gen.sv | 33 +++
 rtl/mems_dac_spi_tx.sv | 199 +++++++++++++++++++
 tb/tb_mems_dac_spi_tx.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mems_spi_pkg.sv
// Shared definitions for the MEMS mirror DAC SPI transmitter.
// Contents: FSM state enum (3-bit), default parameter constants,
// DAC command opcodes shared with the scan controller, and a small
// constant helper used to size counters.
package mems_spi_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SETUP = 3'd2,
    SHIFT = 3'd3,
    GAP   = 3'd4
  } mems_spi_state_e;

  localparam int unsigned MEMS_SPI_WORD_W   = 24;
  localparam int unsigned MEMS_SPI_CLK_DIV  = 2;
  localparam int unsigned MEMS_SPI_DATA_LAT = 1;
  localparam int unsigned MEMS_SPI_GAP_CYC  = 4;

  // DAC command opcode field (top nibble of the command word)
  localparam int unsigned MEMS_DAC_OP_W      = 4;
  localparam logic [3:0]  MEMS_DAC_OP_WR_IN  = 4'h0;
  localparam logic [3:0]  MEMS_DAC_OP_UPDATE = 4'h1;
  localparam logic [3:0]  MEMS_DAC_OP_WR_UPD = 4'h3;
  localparam logic [3:0]  MEMS_DAC_OP_PWR    = 4'h4;
  localparam logic [3:0]  MEMS_DAC_OP_RESET  = 4'h5;
  localparam logic [3:0]  MEMS_DAC_OP_NOP    = 4'hF;

  function automatic int unsigned mems_spi_max(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mems_spi_tick_gen.sv
// SCLK half-period prescaler.
// Ports: clk, rst (sync, active-high), i_run (count enable),
//        o_tick_c (combinational 1-cycle tick every CLK_DIV cycles of run).
// The count restarts from the top whenever run is low, so the first tick
// after run rises lands exactly CLK_DIV cycles later.
module mems_spi_tick_gen
  import mems_spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = MEMS_SPI_CLK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic i_run,
  output logic o_tick_c
);

  localparam int unsigned      CNT_W  = $clog2(CLK_DIV + 1);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  // Down-counter, reloaded while idle and at each boundary
  always_ff @(posedge clk) begin
    if (rst || !i_run || (r_cnt == '0)) begin
      r_cnt <= RELOAD;
    end else begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_tick_c = i_run && (r_cnt == '0);

endmodule

// File: rtl/mems_dac_spi_tx.sv
// SPI transmitter for the MEMS mirror DAC.
// Accepts a start pulse from the scan controller, latches one command word
// from the pattern ROM DATA_LAT cycles later, shifts it MSB-first framed by
// SYNC_n (DAC samples on SCLK falling edge), then holds an inter-word gap.
// Ports: clk, rst (sync, active-high), start, data_in[WORD_W]; busy, done,
//        spi_sclk (idles high), spi_sync_n, spi_din; all outputs registered.
// Optional: `define MEMS_SPI_OVERRUN_EN adds a sticky 'overrun' output set
//           by a start request while a frame is in progress.
module mems_dac_spi_tx
  import mems_spi_pkg::*;
#(
  parameter int unsigned WORD_W   = MEMS_SPI_WORD_W,
  parameter int unsigned CLK_DIV  = MEMS_SPI_CLK_DIV,
  parameter int unsigned DATA_LAT = MEMS_SPI_DATA_LAT,
  parameter int unsigned GAP_CYC  = MEMS_SPI_GAP_CYC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WORD_W-1:0] data_in,
  output logic              busy,
  output logic              done,
  output logic              spi_sclk,
  output logic              spi_sync_n,
`ifdef MEMS_SPI_OVERRUN_EN
  output logic              overrun,
`endif
  output logic              spi_din
);

  localparam int unsigned      BIT_W      = $clog2(WORD_W);
  localparam int unsigned      CNT_W      = $clog2(mems_spi_max(GAP_CYC, DATA_LAT) + 1);
  localparam bit               LAT_ZERO   = (DATA_LAT == 0);
  localparam logic [CNT_W-1:0] LAT_RELOAD = LAT_ZERO ? '0 : CNT_W'(DATA_LAT - 1);
  localparam logic [CNT_W-1:0] GAP_RELOAD = CNT_W'(GAP_CYC - 1);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(WORD_W - 1);

  mems_spi_state_e r_state, w_state_nxt;

  logic              r_busy,   w_busy;
  logic              r_done,   w_done;
  logic              r_sclk,   w_sclk;
  logic              r_sync_n, w_sync_n;
  logic              r_din,    w_din;
  logic [WORD_W-1:0] r_shift,  w_shift;
  logic [BIT_W-1:0]  r_bit,    w_bit;
  logic [CNT_W-1:0]  r_cnt,    w_cnt;

  logic w_run;
  logic w_tick;
  logic w_load;

  assign w_run = (r_state == SETUP) || (r_state == SHIFT);

  mems_spi_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk      (clk),
    .rst      (rst),
    .i_run    (w_run),
    .o_tick_c (w_tick)
  );

  // ROM word capture point: the acceptance edge itself when latency is zero
  assign w_load = ((r_state == IDLE) && start && LAT_ZERO) ||
                  ((r_state == LOAD) && (r_cnt == '0));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = LAT_ZERO ? SETUP : LOAD;
      LOAD:    if (r_cnt == '0) w_state_nxt = SETUP;
      SETUP:   if (w_tick) w_state_nxt = SHIFT;
      SHIFT:   if (w_tick && r_sclk && (r_bit == '0)) w_state_nxt = GAP;
      GAP:     if (r_cnt == '0) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    w_busy   = r_busy;
    w_done   = 1'b0;
    w_sclk   = r_sclk;
    w_sync_n = r_sync_n;
    w_din    = r_din;
    w_shift  = r_shift;
    w_bit    = r_bit;
    w_cnt    = r_cnt;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_busy = 1'b1;
          w_cnt  = LAT_RELOAD;
        end
      end
      LOAD: begin
        if (r_cnt != '0) w_cnt = r_cnt - CNT_W'(1);
      end
      SETUP: begin
        if (w_tick) begin
          w_sclk = 1'b0;
          w_bit  = BIT_LAST;
        end
      end
      SHIFT: begin
        if (w_tick) begin
          if (!r_sclk) begin
            // rising SCLK: present the next bit for the following falling edge
            w_sclk  = 1'b1;
            w_shift = r_shift << 1;
            w_din   = r_shift[WORD_W-2];
          end else if (r_bit == '0) begin
            w_sync_n = 1'b1;
            w_din    = 1'b0;
            w_cnt    = GAP_RELOAD;
          end else begin
            w_sclk = 1'b0;
            w_bit  = r_bit - BIT_W'(1);
          end
        end
      end
      GAP: begin
        if (r_cnt == '0) begin
          w_busy = 1'b0;
          w_done = 1'b1;
        end else begin
          w_cnt = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_busy   = 1'b0;
        w_sclk   = 1'b1;
        w_sync_n = 1'b1;
        w_din    = 1'b0;
      end
    endcase
    if (w_load) begin
      w_shift  = data_in;
      w_sync_n = 1'b0;
      w_din    = data_in[WORD_W-1];
    end
  end

  // Datapath and pin flops
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_sclk   <= 1'b1;
      r_sync_n <= 1'b1;
      r_din    <= 1'b0;
      r_shift  <= '0;
      r_bit    <= '0;
      r_cnt    <= '0;
    end else begin
      r_busy   <= w_busy;
      r_done   <= w_done;
      r_sclk   <= w_sclk;
      r_sync_n <= w_sync_n;
      r_din    <= w_din;
      r_shift  <= w_shift;
      r_bit    <= w_bit;
      r_cnt    <= w_cnt;
    end
  end

`ifdef MEMS_SPI_OVERRUN_EN
  logic r_overrun;

  // Sticky flag for a request that arrived while a frame was in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overrun <= 1'b0;
    end else if (start && (r_state != IDLE)) begin
      r_overrun <= 1'b1;
    end
  end

  assign overrun = r_overrun;
`endif

  assign busy       = r_busy;
  assign done       = r_done;
  assign spi_sclk   = r_sclk;
  assign spi_sync_n = r_sync_n;
  assign spi_din    = r_din;

endmodule

// File: tb/tb_mems_dac_spi_tx.sv
// Self-checking bench for mems_dac_spi_tx: three instances
// (defaults; CLK_DIV=1/DATA_LAT=0; CLK_DIV=5/DATA_LAT=3), a pin-level monitor
// decoding the SPI frames, and expectations computed from the frame timing rules.
module tb_mems_dac_spi_tx;

  localparam int W   = 24;
  localparam int GAP = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  start_v = '0;
  logic [23:0] data_v [3];
  logic [2:0]  busy_v, done_v, sclk_v, sync_v, din_v;
`ifdef MEMS_SPI_OVERRUN_EN
  logic [2:0]  ovr_v;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mems_dac_spi_tx u_dut0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .data_in(data_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .spi_sclk(sclk_v[0]), .spi_sync_n(sync_v[0]),
`ifdef MEMS_SPI_OVERRUN_EN
    .overrun(ovr_v[0]),
`endif
    .spi_din(din_v[0]));

  mems_dac_spi_tx #(.CLK_DIV(1), .DATA_LAT(0)) u_dut1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .data_in(data_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .spi_sclk(sclk_v[1]), .spi_sync_n(sync_v[1]),
`ifdef MEMS_SPI_OVERRUN_EN
    .overrun(ovr_v[1]),
`endif
    .spi_din(din_v[1]));

  mems_dac_spi_tx #(.CLK_DIV(5), .DATA_LAT(3)) u_dut2 (
    .clk(clk), .rst(rst), .start(start_v[2]), .data_in(data_v[2]),
    .busy(busy_v[2]), .done(done_v[2]), .spi_sclk(sclk_v[2]), .spi_sync_n(sync_v[2]),
`ifdef MEMS_SPI_OVERRUN_EN
    .overrun(ovr_v[2]),
`endif
    .spi_din(din_v[2]));

  function automatic int div_of(input int k);
    case (k)
      1:       return 1;
      2:       return 5;
      default: return 2;
    endcase
  endfunction

  function automatic int lat_of(input int k);
    case (k)
      1:       return 0;
      2:       return 3;
      default: return 1;
    endcase
  endfunction

  // Frame timing from the rules: latency, setup half-period, 2 half-periods per bit, gap
  function automatic int exp_busy_len(input int k);
    return lat_of(k) + div_of(k) * (1 + 2 * W) + GAP;
  endfunction

  function automatic int exp_sync_len(input int k);
    return div_of(k) * (1 + 2 * W);
  endfunction

  // Pin monitor state
  logic        prev_busy [3] = '{1'b0, 1'b0, 1'b0};
  logic        prev_sync [3] = '{1'b1, 1'b1, 1'b1};
  logic        prev_sclk [3] = '{1'b1, 1'b1, 1'b1};
  int          busy_run [3]  = '{0, 0, 0};
  int          last_busy [3] = '{0, 0, 0};
  int          sync_run [3]  = '{0, 0, 0};
  int          last_sync [3] = '{0, 0, 0};
  int          high_run [3]  = '{0, 0, 0};
  int          last_gap [3]  = '{0, 0, 0};
  int          hi_run [3]    = '{0, 0, 0};
  int          lo_run [3]    = '{0, 0, 0};
  int          half_err [3]  = '{0, 0, 0};
  int          falls [3]     = '{0, 0, 0};
  int          done_cnt [3]  = '{0, 0, 0};
  int          done_bad [3]  = '{0, 0, 0};
  int          idle_err [3]  = '{0, 0, 0};
  int          exp_done [3]  = '{0, 0, 0};
  logic [23:0] cap [3];

  // Decode pins at the falling clk edge, away from the active edge
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (busy_v[k]) busy_run[k]++;
      else if (prev_busy[k]) begin
        last_busy[k] = busy_run[k];
        busy_run[k]  = 0;
      end
      if (done_v[k]) begin
        done_cnt[k]++;
        if (!(prev_busy[k] && !busy_v[k])) done_bad[k]++;
      end
      if (!sync_v[k]) begin
        if (prev_sync[k]) begin
          last_gap[k] = high_run[k];
          sync_run[k] = 0;
          cap[k]      = '0;
          falls[k]    = 0;
          hi_run[k]   = 0;
          lo_run[k]   = 0;
        end
        high_run[k] = 0;
        sync_run[k]++;
        if (sclk_v[k]) begin
          if (!prev_sclk[k]) begin
            if (lo_run[k] != div_of(k)) half_err[k]++;
            lo_run[k] = 0;
          end
          hi_run[k]++;
        end else begin
          if (prev_sclk[k]) begin
            if (hi_run[k] != div_of(k)) half_err[k]++;
            hi_run[k] = 0;
            cap[k]    = {cap[k][22:0], din_v[k]};
            falls[k]++;
          end
          lo_run[k]++;
        end
      end else begin
        if (!prev_sync[k]) last_sync[k] = sync_run[k];
        high_run[k]++;
        if (!sclk_v[k] || din_v[k]) idle_err[k]++;
      end
      prev_busy[k] = busy_v[k];
      prev_sync[k] = sync_v[k];
      prev_sclk[k] = sclk_v[k];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Issue a start; the ROM word is presented DATA_LAT cycles after acceptance
  task automatic kick(input int k, input logic [23:0] word);
    check($sformatf("busy_pre_start%0d", k), 32'(busy_v[k]), 32'd0);
    start_v[k] = 1'b1;
    data_v[k]  = (lat_of(k) == 0) ? word : 24'($urandom);
    cyc(1);
    start_v[k] = 1'b0;
    data_v[k]  = word;
    check($sformatf("busy_rise%0d", k), 32'(busy_v[k]), 32'd1);
    cyc(lat_of(k));
    data_v[k] = 24'($urandom);
  endtask

  task automatic wait_done(input int k);
    int n;
    n = 0;
    while (!done_v[k] && n < 2000) begin
      cyc(1);
      n++;
    end
    check($sformatf("done_seen%0d", k), 32'(n < 2000), 32'd1);
  endtask

  task automatic verify(input int k, input logic [23:0] word);
    exp_done[k]++;
    check($sformatf("busy_len%0d", k), 32'(last_busy[k]), 32'(exp_busy_len(k)));
    check($sformatf("sync_len%0d", k), 32'(last_sync[k]), 32'(exp_sync_len(k)));
    check($sformatf("word%0d", k), 32'(cap[k]), 32'(word));
    check($sformatf("falls%0d", k), 32'(falls[k]), 32'(W));
    check($sformatf("half_period%0d", k), 32'(half_err[k]), 32'd0);
    check($sformatf("done_count%0d", k), 32'(done_cnt[k]), 32'(exp_done[k]));
  endtask

  initial begin
    logic [23:0] w;
    int n;
    for (int k = 0; k < 3; k++) data_v[k] = '0;

    // Reset held with start asserted
    rst = 1'b1;
    start_v = 3'b111;
    cyc(3);
    check("rst_busy", 32'(busy_v[0]), 32'd0);
    check("rst_sclk", 32'(sclk_v[0]), 32'd1);
    check("rst_sync", 32'(sync_v[0]), 32'd1);
    check("rst_din", 32'(din_v[0]), 32'd0);
    check("rst_done", 32'(done_v[0]), 32'd0);
    rst = 1'b0;
    start_v = '0;
    cyc(4);
    check("rst_no_frame", 32'(busy_v), 32'd0);
    check("rst_no_done", 32'(done_cnt[0]), 32'd0);

    // Single frame with the reference word
    kick(0, 24'h3FA5C3);
    wait_done(0);
    cyc(1);
    verify(0, 24'h3FA5C3);
    check("default_busy_103", 32'(last_busy[0]), 32'd103);
    check("default_sync_98", 32'(last_sync[0]), 32'd98);

    // Random words with random idle spacing
    for (int i = 0; i < 6; i++) begin
      cyc($urandom_range(0, 4));
      w = 24'($urandom);
      kick(0, w);
      wait_done(0);
      cyc(1);
      verify(0, w);
    end

    // Back-to-back: second start in the done cycle
    kick(0, 24'h000001);
    wait_done(0);
    kick(0, 24'h800000);
    verify(0, 24'h000001);
    wait_done(0);
    cyc(1);
    verify(0, 24'h800000);
    check("b2b_gap_ge4", 32'(last_gap[0] >= GAP), 32'd1);

`ifdef MEMS_SPI_OVERRUN_EN
    check("overrun_clear", 32'(ovr_v[0]), 32'd0);
`endif

    // Start while busy is ignored
    w = 24'($urandom);
    kick(0, w);
    cyc(8);
    start_v[0] = 1'b1;
    cyc(1);
    start_v[0] = 1'b0;
    wait_done(0);
    cyc(1);
    verify(0, w);
    cyc(150);
    check("ignored_no_done", 32'(done_cnt[0]), 32'(exp_done[0]));
    check("ignored_idle", 32'(busy_v[0]), 32'd0);
`ifdef MEMS_SPI_OVERRUN_EN
    check("overrun_set", 32'(ovr_v[0]), 32'd1);
`endif

    // Reset mid-frame at bit 12
    kick(0, 24'($urandom));
    n = 0;
    while (falls[0] < 12 && n < 2000) begin
      cyc(1);
      n++;
    end
    check("reach_bit12", 32'(n < 2000), 32'd1);
    rst = 1'b1;
    cyc(1);
    check("abort_sync", 32'(sync_v[0]), 32'd1);
    check("abort_sclk", 32'(sclk_v[0]), 32'd1);
    check("abort_busy", 32'(busy_v[0]), 32'd0);
    check("abort_done", 32'(done_v[0]), 32'd0);
`ifdef MEMS_SPI_OVERRUN_EN
    check("overrun_rst", 32'(ovr_v[0]), 32'd0);
`endif
    rst = 1'b0;
    cyc(3);
    check("abort_no_done", 32'(done_cnt[0]), 32'(exp_done[0]));
    w = 24'($urandom);
    kick(0, w);
    wait_done(0);
    cyc(1);
    verify(0, w);

    // Parameter sweep instances
    for (int k = 1; k < 3; k++) begin
      for (int i = 0; i < 3; i++) begin
        w = 24'($urandom);
        kick(k, w);
        wait_done(k);
        cyc(1);
        verify(k, w);
        cyc($urandom_range(0, 3));
      end
    end

    for (int k = 0; k < 3; k++) begin
      check($sformatf("done_alignment%0d", k), 32'(done_bad[k]), 32'd0);
      check($sformatf("idle_pins%0d", k), 32'(idle_err[k]), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
